// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake and divided-clock outputs of clk_div_ctrl.
// master = control side issuing configurations, slave = the controller itself.
interface clk_div_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_en;
    logic             clk_div;
    logic             tick;
    logic             busy;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_div, cfg_en,
        input  cfg_ready, clk_div, tick, busy, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_en,
        output cfg_ready, clk_div, tick, busy, cfg_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time clock-divider controller: divisor/enable changes take effect only at
// full-period boundaries. Optional macro CLK_DIV_CTRL_ERR_EN rejects cfg_div==0.
module clk_div_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 25_000_000
) (
    input logic           clk,
    input logic           rst,
    clk_div_ctrl_if.slave ctrl
);
    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] count, count_d;
    logic [WIDTH-1:0] div, div_d;
    logic [WIDTH-1:0] div_next, div_next_d;
    logic             en_next, en_next_d;
    logic             clk_div_r, clk_div_d;
    logic             tick_r, tick_d;
    logic             err_r, err_d;

    logic             transfer;
    logic             accept;
    logic             cfg_zero;
    logic [WIDTH-1:0] cfg_div_eff;
    logic             wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            div       <= RESET_DIV;
            div_next  <= RESET_DIV;
            en_next   <= 1'b0;
            clk_div_r <= 1'b0;
            tick_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            div       <= div_d;
            div_next  <= div_next_d;
            en_next   <= en_next_d;
            clk_div_r <= clk_div_d;
            tick_r    <= tick_d;
            err_r     <= err_d;
        end
    end

    always_comb begin
        transfer = ctrl.cfg_valid && (state != PEND);
        cfg_zero = (ctrl.cfg_div == '0);
`ifdef CLK_DIV_CTRL_ERR_EN
        cfg_div_eff = ctrl.cfg_div;
        accept      = transfer && !cfg_zero;
        err_d       = transfer && cfg_zero;
`else
        cfg_div_eff = cfg_zero ? ONE : ctrl.cfg_div;
        accept      = transfer;
        err_d       = 1'b0;
`endif
        wrap = (count == (div - ONE));

        state_d    = state;
        count_d    = count;
        div_d      = div;
        div_next_d = div_next;
        en_next_d  = en_next;
        clk_div_d  = clk_div_r;
        tick_d     = 1'b0;

        case (state)
            IDLE: begin
                count_d   = '0;
                clk_div_d = 1'b0;
                if (accept) begin
                    div_d = cfg_div_eff;
                    if (ctrl.cfg_en) begin
                        state_d = RUN;
                    end
                end
            end

            RUN, PEND: begin
                if (wrap) begin
                    count_d   = '0;
                    clk_div_d = ~clk_div_r;
                    tick_d    = 1'b1;
                end else begin
                    count_d = count + ONE;
                end

                // A request accepted on a boundary still waits for the next 1->0 edge,
                // because the PEND check below only runs once state is already PEND.
                if (state == RUN) begin
                    if (accept) begin
                        div_next_d = cfg_div_eff;
                        en_next_d  = ctrl.cfg_en;
                        state_d    = PEND;
                    end
                end else if (wrap && clk_div_r) begin
                    div_d   = div_next;
                    state_d = en_next ? RUN : IDLE;
                end
            end

            default: begin
                state_d   = IDLE;
                count_d   = '0;
                clk_div_d = 1'b0;
            end
        endcase
    end

    assign ctrl.cfg_ready = (state != PEND);
    assign ctrl.busy      = (state != IDLE);
    assign ctrl.clk_div   = clk_div_r;
    assign ctrl.tick      = tick_r;
    assign ctrl.cfg_err   = err_r;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: stimulus pushes the expected tick schedule,
// a negedge monitor pops an entry on every tick and checks edge number and level.
module tb_clk_div_ctrl;
    localparam int unsigned W = 16;

    typedef struct {
        int   edge_n;
        logic val;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   fails;
    exp_t exp_q[$];
    logic prev_div;

    clk_div_ctrl_if #(.WIDTH(W)) bus ();

    clk_div_ctrl #(
        .WIDTH      (W),
        .DEFAULT_DIV(10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctrl(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Toggles at start+div*k; odd k is a rising edge.
    task automatic push_run(input int start, input int div, input int k_first, input int k_last);
        for (int k = k_first; k <= k_last; k++) begin
            exp_t e;
            e.edge_n = start + div * k;
            e.val    = (k % 2 == 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge clk);
        chk("schedule", cyc, e);
    endtask

    // Holds the request for one edge; returns the number of the transfer edge.
    task automatic xfer(input int d, input bit en, output int e);
        chk("ready_before_xfer", bus.cfg_ready, 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = W'(d);
        bus.cfg_en    = en;
        e = cyc + 1;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_div = bus.clk_div;
        end else begin
            if (bus.tick) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_tick: got tick at cyc %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("tick_edge", cyc, e.edge_n);
                    chk("tick_level", bus.clk_div, e.val);
                end
            end else begin
                chk("no_toggle_without_tick", bus.clk_div, prev_div);
            end
            prev_div = bus.clk_div;
        end
    end

    initial begin
        int a, b, c, d, e, t;
        checks = 0;
        fails  = 0;
        rst           = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        bus.cfg_en    = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_clk_div", bus.clk_div, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.cfg_ready, 1);
        chk("rst_tick", bus.tick, 0);
        chk("rst_err", bus.cfg_err, 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_clk_div", bus.clk_div, 0);

        // IDLE transfer with en=0: divisor only, no activity
        xfer(3, 1'b0, t);
        chk("idle_noen_busy", bus.busy, 0);
        repeat (10) @(negedge clk);
        chk("idle_noen_clk_div", bus.clk_div, 0);

        // Start div=3, then switch to div=5 mid high phase
        xfer(3, 1'b1, a);
        chk("run_busy", bus.busy, 1);
        push_run(a, 3, 1, 10);
        wait_until(a + 27);
        chk("high_phase", bus.clk_div, 1);
        xfer(5, 1'b1, t);
        chk("pend_edge", t, a + 28);
        chk("pend_ready0", bus.cfg_ready, 0);
        chk("pend_busy", bus.busy, 1);
        b = a + 30;
        push_run(b, 5, 1, 4);
        wait_until(a + 29);
        chk("pend_ready1", bus.cfg_ready, 0);
        wait_until(b);
        chk("applied_ready", bus.cfg_ready, 1);

        // div=5 -> div=2, then stop with en=0
        wait_until(b + 11);
        xfer(2, 1'b1, t);
        c = b + 20;
        push_run(c, 2, 1, 4);
        wait_until(c + 6);
        xfer(2, 1'b0, t);
        wait_until(c + 8);
        chk("stop_busy", bus.busy, 0);
        chk("stop_clk_div", bus.clk_div, 0);
        chk("stop_ready", bus.cfg_ready, 1);
        repeat (30) @(negedge clk);
        chk("stopped_busy", bus.busy, 0);

        // Transfer on a 1->0 boundary applies one full period later
        xfer(3, 1'b1, d);
        push_run(d, 3, 1, 4);
        wait_until(d + 5);
        xfer(4, 1'b1, t);
        chk("bnd_ready0", bus.cfg_ready, 0);
        wait_until(d + 11);
        chk("bnd_ready1", bus.cfg_ready, 0);
        wait_until(d + 12);
        chk("bnd_applied", bus.cfg_ready, 1);
        push_run(d + 12, 4, 1, 1);

        // Reset mid-PEND discards the pending request
        wait_until(d + 17);
        xfer(7, 1'b1, t);
        chk("pre_rst_ready", bus.cfg_ready, 0);
        wait_until(d + 19);
        chk("pre_rst_clk_div", bus.clk_div, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_clk_div", bus.clk_div, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_ready", bus.cfg_ready, 1);
        chk("async_rst_tick", bus.tick, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_clk_div", bus.clk_div, 0);

        // cfg_div = 0
        xfer(0, 1'b1, e);
`ifdef CLK_DIV_CTRL_ERR_EN
        chk("zero_err_pulse", bus.cfg_err, 1);
        chk("zero_err_busy", bus.busy, 0);
        @(negedge clk);
        chk("zero_err_clear", bus.cfg_err, 0);
        chk("zero_err_clk_div", bus.clk_div, 0);
        repeat (10) @(negedge clk);
`else
        chk("zero_no_err", bus.cfg_err, 0);
        push_run(e, 1, 1, 10);
        wait_until(e + 7);
        xfer(1, 1'b0, t);
        wait_until(e + 10);
        chk("zero_stop_busy", bus.busy, 0);
        chk("zero_stop_clk_div", bus.clk_div, 0);
        repeat (20) @(negedge clk);
`endif
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for the programmable clock-divider datapath: accepts divisor/enable configurations over a valid/ready handshake and sequences a single half-period counter. The output divided clock starts, stops and changes frequency only at full-period boundaries, so `clk_div` never produces a runt pulse. It sits between control logic (UART/FSM/register file) and the consumers of `clk_div`/`tick`.

## Interface
Parameters:
- `WIDTH`, 32, width of divisor and internal counter.
- `DEFAULT_DIV`, 25_000_000, divisor loaded at reset (half-period in `clk` cycles; 1 Hz at 50 MHz).

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cfg_valid` input 1: configuration request.
- `cfg_ready` output 1: controller can accept a configuration.
- `cfg_div` input WIDTH: requested half-period in `clk` cycles.
- `cfg_en` input 1: 1 = run with `cfg_div`, 0 = stop after the current period.
- `clk_div` output 1: divided clock, registered.
- `tick` output 1: one-cycle pulse on every `clk_div` toggle, registered.
- `busy` output 1: high when not IDLE.
- `cfg_err` output 1: one-cycle pulse on a rejected configuration (macro-dependent).

## Operation
- Registers: `state`, `count` (WIDTH), `div` (WIDTH), `div_next`, `en_next`, `clk_div`, `tick`.
- Handshake: transfer when `cfg_valid && cfg_ready`. `cfg_ready` = (state != PEND), combinational from state. Inputs are sampled only on transfer.
- States:
  - IDLE: `clk_div`=0, `count` held at 0. On transfer: `div` <= `cfg_div`. If `cfg_en`=1, go to RUN; otherwise stay in IDLE.
  - RUN: `count` increments. When `count == div-1`: `count` <= 0, `clk_div` toggles, `tick`=1. On transfer: latch `div_next`/`en_next`, go to PEND.
  - PEND: counting continues with the old `div`. At the next toggle where `clk_div` goes 1->0 (end of a full period): `div` <= `div_next`, `count` <= 0. If `en_next`, go to RUN; otherwise go to IDLE.
- Half-period = `div` cycles; full period = 2·`div` cycles. `div`=1 gives `clk_div` at `clk`/2.
- Comparison `count == div-1` is WIDTH-bit unsigned. `count` never exceeds `div-1`.
- A transfer in the same cycle as a period boundary enters PEND and takes effect at the *following* boundary.
- A transfer in IDLE with `cfg_en`=0 updates `div` only; no output activity.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, `count` 0, `div` DEFAULT_DIV, `clk_div` 0, `tick` 0, `cfg_err` 0. `cfg_ready` is 1 while in reset.
- Reset mid-operation: all registers return to reset values asynchronously. A pending config is discarded.
- Start latency: transfer at cycle T in IDLE gives RUN at T+1. First `clk_div` rise and `tick` occur at T+`div`+1.
- `tick` is coincident with the `clk_div` edge (same register update).
- Stop: `clk_div` is low in the cycle PEND->IDLE occurs, with no further `tick`.
- `cfg_ready` deasserts the cycle after a RUN transfer and reasserts the cycle after the boundary that applies the config.

## Configuration
- `CLK_DIV_CTRL_ERR_EN` defined:
  - A transfer with `cfg_div`==0 is accepted (handshake completes) but discarded.
  - `cfg_err` pulses one cycle later; state, `div` and outputs are unchanged.
- Undefined:
  - `cfg_div`==0 is treated as 1.
  - `cfg_err` is tied to 0.

## Test plan
- Reset then IDLE: `clk_div`=0, `busy`=0, `cfg_ready`=1. Deassert `rst` with `cfg_valid`=0 for 100 cycles -> no `tick`.
- Transfer {div=3, en=1} in IDLE at T -> `clk_div` rises at T+4, falls at T+7, period 6. `tick` fires every 3 cycles.
- Running div=3, transfer {div=5, en=1} mid-high-phase -> old period completes, then period 10 from the 1->0 edge. `cfg_ready` is low only during PEND.
- Running div=2, transfer {div=2, en=0} -> current period finishes, `clk_div` held 0, `busy`=0, no further `tick`.
- Transfer coincident with a 1->0 boundary -> applied one full period later. Assert `rst` mid-PEND -> immediate reset values, pending config lost.
- `cfg_div`=0, en=1: with `CLK_DIV_CTRL_ERR_EN`, `cfg_err` pulses once and state is unchanged. Without it, `clk_div` runs at `clk`/2.
